// File: rtl/restoring_div_seq.sv
// Multi-cycle radix-2 restoring divider: DW_N-bit dividend / DW_D-bit divisor,
// one quotient bit per clock, valid/ready handshakes on input and result.
module restoring_div_seq #(
    parameter int unsigned DW_N = 32,
    parameter int unsigned DW_D = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_N-1:0] dividend,
    input  logic [DW_D-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_N-1:0] quotient,
    output logic [DW_D-1:0] remainder,
    output logic            div_by_zero
);

    localparam int unsigned CW = (DW_N > 1) ? $clog2(DW_N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [DW_D-1:0] dsr_q, dsr_d;
    logic [DW_N-1:0] q_q, q_d;
    logic [DW_D:0]   r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW_N-1:0] quo_q, quo_d;
    logic [DW_D-1:0] rem_q, rem_d;
    logic            dbz_q, dbz_d;
    logic            vld_q, vld_d;

    logic            accept;
    logic [DW_D:0]   trial;
    logic [DW_D:0]   diff;
    logic            ge;
    logic [DW_N-1:0] q_next;
    logic [DW_D:0]   r_next;

    assign in_ready    = (state_q == IDLE) && rst_n;
    assign out_valid   = vld_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    always_comb begin
        state_d = state_q;
        dsr_d   = dsr_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        vld_d   = vld_q;

        accept = in_valid && in_ready;
        trial  = {r_q[DW_D-1:0], q_q[DW_N-1]};
        diff   = trial - {1'b0, dsr_q};
        ge     = (trial >= {1'b0, dsr_q});
        q_next = {q_q[DW_N-2:0], ge};
        r_next = ge ? diff : trial;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (divisor != '0) begin
                        state_d = BUSY;
                        dsr_d   = divisor;
                        q_d     = dividend;
                        r_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend[DW_D-1:0];
                        dbz_d   = 1'b1;
                    end
                end
            end
            BUSY: begin
                q_d   = q_next;
                r_d   = r_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW_N - 1)) begin
                    state_d = DONE;
                    quo_d   = q_next;
                    rem_d   = r_next[DW_D-1:0];
                    dbz_d   = 1'b0;
                    vld_d   = 1'b1;
                end
            end
            DONE: begin
                // Zero-divisor path enters DONE with valid low; raise it one edge later.
                if (!vld_q) begin
                    vld_d = 1'b1;
                end else if (out_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dsr_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dsr_q   <= dsr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: tb/tb_restoring_div_seq.sv
// Directed and randomised checks of restoring_div_seq (32/16) with immediate assertions.
module tb_restoring_div_seq;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [31:0] dividend, quotient;
    logic [15:0] divisor, remainder;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    restoring_div_seq #(.DW_N(32), .DW_D(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [15:0] b);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] a, eq;
        logic [15:0] b, er;
        logic        ez;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // 1000 / 7
        start_op(32'd1000, 16'd7);
        wait_done(lat);
        check("t1_latency", lat, 32);
        check("t1_q", quotient, 142);
        check("t1_r", remainder, 6);
        check("t1_dbz", div_by_zero, 0);
        consume();
        check("t1_out_valid_clr", out_valid, 0);
        check("t1_in_ready", in_ready, 1);

        // max / max, and dividend < divisor
        start_op(32'hFFFF_FFFF, 16'hFFFF);
        wait_done(lat);
        check("t2a_q", quotient, 32'h0001_0001);
        check("t2a_r", remainder, 0);
        consume();
        start_op(32'd5, 16'd9);
        wait_done(lat);
        check("t2b_q", quotient, 0);
        check("t2b_r", remainder, 5);
        consume();

        // divide by zero
        start_op(32'd1234, 16'd0);
        wait_done(lat);
        check("t3_latency", lat, 1);
        check("t3_q", quotient, 32'hFFFF_FFFF);
        check("t3_r", remainder, 16'h04D2);
        check("t3_dbz", div_by_zero, 1);
        consume();

        // backpressure: 50000 / 300 = 166 r 200
        start_op(32'd50000, 16'd300);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            dividend = $urandom;
            divisor  = 16'd3;
            tick();
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_q", quotient, 166);
            check("t4_hold_r", remainder, 200);
            check("t4_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        consume();
        check("t4_released", out_valid, 0);
        check("t4_in_ready_after", in_ready, 1);
        check("t4_q_held", quotient, 166);

        // reset in the middle of an iteration sequence
        start_op(32'd1000, 16'd7);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("t5_in_ready_in_rst", in_ready, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_q", quotient, 0);
        check("t5_r", remainder, 0);
        check("t5_dbz", div_by_zero, 0);
        check("t5_in_ready", in_ready, 1);
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        check("t5_no_stale_valid", seen, 0);
        start_op(32'd100, 16'd10);
        wait_done(lat);
        check("t5_latency", lat, 32);
        check("t5_q_after", quotient, 10);
        check("t5_r_after", remainder, 0);
        consume();

        // back-to-back random ops; odd ones are 16x16 products divided by one factor
        for (int i = 0; i < 1000; i++) begin
            if (i % 2 == 1) begin
                a  = {16'h0, 16'($urandom)};
                b  = 16'($urandom_range(1, 65535));
                eq = a;
                er = '0;
                ez = 1'b0;
                a  = a * {16'h0, b};
            end else begin
                a = $urandom;
                b = (i % 10 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
                if (b == '0) begin
                    eq = '1;
                    er = a[15:0];
                    ez = 1'b1;
                end else begin
                    eq = a / {16'h0, b};
                    er = 16'(a % {16'h0, b});
                    ez = 1'b0;
                end
            end
            start_op(a, b);
            wait_done(lat);
            check("rand_done", out_valid, 1);
            check("rand_q", quotient, eq);
            check("rand_r", remainder, er);
            check("rand_dbz", div_by_zero, ez);
            consume();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
